// File: rtl/uc_seq.sv
// ---------------------------------------------------------------------------
// uc_seq : sequencing control unit for the single-cycle 16-bit CPU datapath.
//
// Decodes INST[31:16] every cycle and drives the datapath strobes. On top of
// the plain decode it adds:
//   - conditional branches on the registered Z/C flags
//   - a timed WAIT stall
//   - HALT with level-sensitive resume
//   - a return-stack depth tracker that faults on overflow/underflow
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   reset    in   synchronous, active-high reset
//   opcode   in   [15:0] INST[31:16] of the current instruction
//   z        in   registered zero flag from the datapath
//   carry    in   registered carry flag from the datapath
//   resume   in   leave HALT (level, sampled on clk)
//   s_inc    out  1 = PC+1, 0 = jump target
//   s_inm    out  immediate into the ALU A path
//   we3      out  register file write enable
//   wez      out  Z/C flag register enable
//   push     out  push return address (PC+1)
//   pop      out  pop return address into PC
//   op_alu   out  [2:0] ALU operation
//   pc_en    out  PC register load enable
//   halted   out  1 while in HALT
//   fault    out  1 while in FAULT (sticky until reset)
//   illegal  out  one-cycle pulse on a reserved opcode
// ---------------------------------------------------------------------------
module uc_seq #(
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] opcode,
    input  logic        z,
    input  logic        carry,
    input  logic        resume,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic        push,
    output logic        pop,
    output logic [2:0]  op_alu,
    output logic        pc_en,
    output logic        halted,
    output logic        fault,
    output logic        illegal
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] MAX_DEPTH = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [7:0]      waitCnt_q, waitCnt_d;

    logic            sInc, sInm, we3Int, wezInt, pushInt, popInt;
    logic [2:0]      opAlu;
    logic            pcEn, illegalInt;

    // Decode and next-state logic. Outputs are a pure function of the
    // current state, opcode and flags; only state, depth and the wait
    // counter are registered.
    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        waitCnt_d  = waitCnt_q;
        sInc       = 1'b1;
        sInm       = 1'b0;
        we3Int     = 1'b0;
        wezInt     = 1'b0;
        pushInt    = 1'b0;
        popInt     = 1'b0;
        opAlu      = 3'b000;
        pcEn       = 1'b1;
        illegalInt = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (!opcode[15]) begin
                    opAlu  = opcode[14:12];
                    we3Int = 1'b1;
                    wezInt = 1'b1;
                end else begin
                    case (opcode[14:12])
                        3'b000: begin
                            sInm   = 1'b1;
                            we3Int = 1'b1;
                        end
                        3'b001: sInc = 1'b0;
                        // Branches take the jump target (s_inc=0) when
                        // the condition holds on the already registered flags.
                        3'b010: sInc = ~z;
                        3'b011: sInc = z;
                        3'b100: sInc = ~carry;
                        3'b101: sInc = carry;
                        3'b110: begin
                            case (opcode[11:8])
                                4'h0: begin
                                    if (depth_q < MAX_DEPTH) begin
                                        pushInt = 1'b1;
                                        sInc    = 1'b0;
                                        depth_d = depth_q + DEPTH_ONE;
                                    end else begin
                                        pcEn    = 1'b0;
                                        state_d = ST_FAULT;
                                    end
                                end
                                4'h1: begin
                                    if (depth_q != '0) begin
                                        popInt  = 1'b1;
                                        depth_d = depth_q - DEPTH_ONE;
                                    end else begin
                                        pcEn    = 1'b0;
                                        state_d = ST_FAULT;
                                    end
                                end
                                4'h2: begin
                                end
                                4'h3: begin
                                    pcEn    = 1'b0;
                                    state_d = ST_HALT;
                                end
                                4'h4: begin
                                    // WAIT 0 degenerates to a NOP.
                                    if (opcode[7:0] != 8'd0) begin
                                        pcEn      = 1'b0;
                                        waitCnt_d = opcode[7:0];
                                        state_d   = ST_WAIT;
                                    end
                                end
                                default: illegalInt = 1'b1;
                            endcase
                        end
                        default: illegalInt = 1'b1;
                    endcase
                end
            end

            // The RUN cycle that issued WAIT N already counts as one stall
            // cycle, so counting N down to 1 here gives N+1 cycles in total.
            ST_WAIT: begin
                sInc = 1'b0;
                pcEn = 1'b0;
                if (waitCnt_q == 8'd1) begin
                    sInc    = 1'b1;
                    pcEn    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    waitCnt_d = waitCnt_q - 8'd1;
                end
            end

            // On resume the PC advances to PC+1 in this same cycle so the
            // instruction after HALT is fetched on returning to RUN.
            ST_HALT: begin
                sInc = resume;
                pcEn = resume;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end

            ST_FAULT: begin
                sInc = 1'b0;
                pcEn = 1'b0;
            end
        endcase
    end

    // Reset forces every output low, independent of the held-over state.
    assign s_inc   = ~reset & sInc;
    assign s_inm   = ~reset & sInm;
    assign we3     = ~reset & we3Int;
    assign wez     = ~reset & wezInt;
    assign push    = ~reset & pushInt;
    assign pop     = ~reset & popInt;
    assign op_alu  = reset ? 3'b000 : opAlu;
    assign pc_en   = ~reset & pcEn;
    assign halted  = ~reset & (state_q == ST_HALT);
    assign fault   = ~reset & (state_q == ST_FAULT);
    assign illegal = ~reset & illegalInt;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            depth_q   <= '0;
            waitCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            depth_q   <= depth_d;
            waitCnt_q <= waitCnt_d;
        end
    end

endmodule

// File: tb/tb_uc_seq.sv
// ---------------------------------------------------------------------------
// tb_uc_seq : directed self-checking bench for uc_seq.
//
// Each step drives one cycle of inputs, pushes the expected output vector to
// a scoreboard queue, and pops/compares it at the following falling edge.
// Output vector order:
//   {s_inc, s_inm, we3, wez, push, pop, op_alu[2:0], pc_en, halted, fault, illegal}
// ---------------------------------------------------------------------------
module tb_uc_seq;

    logic        clk;
    logic        reset;
    logic [15:0] opcode;
    logic        z;
    logic        carry;
    logic        resume;
    logic        s_inc, s_inm, we3, wez, push, pop;
    logic [2:0]  op_alu;
    logic        pc_en, halted, fault, illegal;

    logic [12:0] expQ[$];
    string       tagQ[$];
    int          testsRun;
    int          testsFailed;

    uc_seq #(.STACK_DEPTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .opcode  (opcode),
        .z       (z),
        .carry   (carry),
        .resume  (resume),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we3     (we3),
        .wez     (wez),
        .push    (push),
        .pop     (pop),
        .op_alu  (op_alu),
        .pc_en   (pc_en),
        .halted  (halted),
        .fault   (fault),
        .illegal (illegal)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an expected output vector from individual fields.
    function automatic logic [12:0] ex(input logic sInc, input logic sInm,
                                       input logic w3, input logic wz,
                                       input logic ps, input logic pp,
                                       input logic [2:0] op, input logic pe,
                                       input logic hl, input logic ft,
                                       input logic il);
        return {sInc, sInm, w3, wz, ps, pp, op, pe, hl, ft, il};
    endfunction

    localparam logic [12:0] ZERO    = 13'b0;
    localparam logic [12:0] NOPV    = 13'b1_0_0_0_0_0_000_1_0_0_0;
    localparam logic [12:0] TAKEN   = 13'b0_0_0_0_0_0_000_1_0_0_0;
    localparam logic [12:0] STALL   = 13'b1_0_0_0_0_0_000_0_0_0_0;
    localparam logic [12:0] PUSHV   = 13'b0_0_0_0_1_0_000_1_0_0_0;
    localparam logic [12:0] POPV    = 13'b1_0_0_0_0_1_000_1_0_0_0;
    localparam logic [12:0] FAULTV  = 13'b0_0_0_0_0_0_000_0_0_1_0;
    localparam logic [12:0] HALTV   = 13'b0_0_0_0_0_0_000_0_1_0_0;

    // Pops the oldest expectation and compares it with the live outputs.
    task automatic checkOutput();
        logic [12:0] observed;
        logic [12:0] expected;
        string       tag;
        observed = {s_inc, s_inm, we3, wez, push, pop, op_alu, pc_en, halted, fault, illegal};
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $error("[TB] FAIL scoreboard_empty observed=%b", observed);
        end else begin
            expected = expQ.pop_front();
            tag      = tagQ.pop_front();
            assert (observed === expected) else begin
                testsFailed++;
                $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
            end
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, records the
    // expected outputs, then checks them on the falling edge.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic [15:0] op, input logic zIn,
                                 input logic cIn, input logic res,
                                 input logic [12:0] expv);
        @(posedge clk);
        #1;
        reset  = rst;
        opcode = op;
        z      = zIn;
        carry  = cIn;
        resume = res;
        expQ.push_back(expv);
        tagQ.push_back(tag);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset  = 1'b1;
        opcode = 16'h0000;
        z      = 1'b0;
        carry  = 1'b0;
        resume = 1'b0;

        // Reset holds everything low even with an ALU opcode present.
        applyStimulus("reset0", 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, ZERO);
        applyStimulus("reset1", 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, ZERO);

        // ALU op, LOADI.
        applyStimulus("alu011", 1'b0, 16'h3000, 1'b0, 1'b0, 1'b0,
                      ex(1, 0, 1, 1, 0, 0, 3'b011, 1, 0, 0, 0));
        applyStimulus("alu101", 1'b0, 16'h5ABC, 1'b1, 1'b1, 1'b0,
                      ex(1, 0, 1, 1, 0, 0, 3'b101, 1, 0, 0, 0));
        applyStimulus("loadi", 1'b0, 16'h8012, 1'b0, 1'b0, 1'b0,
                      ex(1, 1, 1, 0, 0, 0, 3'b000, 1, 0, 0, 0));

        // Jumps and branches.
        applyStimulus("jmp",      1'b0, 16'h9000, 1'b0, 1'b0, 1'b0, TAKEN);
        applyStimulus("jz_z1",    1'b0, 16'hA000, 1'b1, 1'b0, 1'b0, TAKEN);
        applyStimulus("jz_z0",    1'b0, 16'hA000, 1'b0, 1'b0, 1'b0, NOPV);
        applyStimulus("jnz_z0",   1'b0, 16'hB000, 1'b0, 1'b0, 1'b0, TAKEN);
        applyStimulus("jnz_z1",   1'b0, 16'hB000, 1'b1, 1'b0, 1'b0, NOPV);
        applyStimulus("jc_c1",    1'b0, 16'hC000, 1'b0, 1'b1, 1'b0, TAKEN);
        applyStimulus("jc_c0",    1'b0, 16'hC000, 1'b1, 1'b0, 1'b0, NOPV);
        applyStimulus("jnc_c0",   1'b0, 16'hD000, 1'b0, 1'b0, 1'b0, TAKEN);
        applyStimulus("jnc_c1",   1'b0, 16'hD000, 1'b0, 1'b1, 1'b0, NOPV);

        // WAIT 3: pc_en low for three cycles, high on the fourth.
        applyStimulus("wait3_c0", 1'b0, 16'hE403, 1'b0, 1'b0, 1'b0, STALL);
        applyStimulus("wait3_c1", 1'b0, 16'hE403, 1'b0, 1'b0, 1'b0, ZERO);
        applyStimulus("wait3_c2", 1'b0, 16'hE403, 1'b0, 1'b0, 1'b0, ZERO);
        applyStimulus("wait3_c3", 1'b0, 16'hE403, 1'b0, 1'b0, 1'b0, NOPV);
        applyStimulus("wait3_run", 1'b0, 16'hE200, 1'b0, 1'b0, 1'b0, NOPV);

        // WAIT 0 behaves as NOP.
        applyStimulus("wait0",     1'b0, 16'hE400, 1'b0, 1'b0, 1'b0, NOPV);
        applyStimulus("wait0_run", 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0,
                      ex(1, 0, 1, 1, 0, 0, 3'b001, 1, 0, 0, 0));

        // Eight CALLs fill the stack, the ninth overflows into FAULT.
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("call%0d", i), 1'b0, 16'hE000, 1'b0, 1'b0, 1'b0, PUSHV);
        end
        applyStimulus("call_ovf", 1'b0, 16'hE000, 1'b0, 1'b0, 1'b0, STALL);
        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("fault_hold%0d", i), 1'b0,
                          16'(i * 16'h0C01), i[0], i[1], i[2], FAULTV);
        end
        applyStimulus("fault_reset", 1'b1, 16'hE000, 1'b0, 1'b0, 1'b0, ZERO);
        applyStimulus("post_reset_call", 1'b0, 16'hE000, 1'b0, 1'b0, 1'b0, PUSHV);
        applyStimulus("post_reset_ret",  1'b0, 16'hE100, 1'b0, 1'b0, 1'b0, POPV);

        // RET at depth 0 underflows.
        applyStimulus("ret_udf",   1'b0, 16'hE100, 1'b0, 1'b0, 1'b0, STALL);
        applyStimulus("ret_fault", 1'b0, 16'hE200, 1'b0, 1'b0, 1'b0, FAULTV);
        applyStimulus("reset2",    1'b1, 16'hE200, 1'b0, 1'b0, 1'b0, ZERO);

        // CALL then RET balances, a second RET then underflows.
        applyStimulus("cr_call",  1'b0, 16'hE000, 1'b0, 1'b0, 1'b0, PUSHV);
        applyStimulus("cr_ret",   1'b0, 16'hE100, 1'b0, 1'b0, 1'b0, POPV);
        applyStimulus("cr_nop",   1'b0, 16'hE200, 1'b0, 1'b0, 1'b0, NOPV);
        applyStimulus("cr_ret2",  1'b0, 16'hE100, 1'b0, 1'b0, 1'b0, STALL);
        applyStimulus("cr_fault", 1'b0, 16'hE200, 1'b0, 1'b0, 1'b0, FAULTV);
        applyStimulus("reset3",   1'b1, 16'hE200, 1'b0, 1'b0, 1'b0, ZERO);

        // HALT, hold, resume.
        applyStimulus("halt", 1'b0, 16'hE300, 1'b0, 1'b0, 1'b0, STALL);
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("halt_hold%0d", i), 1'b0, 16'hE300, 1'b0, 1'b0, 1'b0, HALTV);
        end
        applyStimulus("halt_resume", 1'b0, 16'hE200, 1'b0, 1'b0, 1'b1,
                      ex(1, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0, 0));
        applyStimulus("halt_run", 1'b0, 16'hE200, 1'b0, 1'b0, 1'b0, NOPV);

        // Reserved opcodes pulse illegal for one cycle and act as NOP.
        applyStimulus("illegal_f123", 1'b0, 16'hF123, 1'b0, 1'b0, 1'b0,
                      ex(1, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1));
        applyStimulus("illegal_clear", 1'b0, 16'hE200, 1'b0, 1'b0, 1'b0, NOPV);
        applyStimulus("illegal_e5", 1'b0, 16'hE5FF, 1'b0, 1'b0, 1'b0,
                      ex(1, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1));
        applyStimulus("illegal_run", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0,
                      ex(1, 0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 0));

        // Reset in the middle of a WAIT returns straight to RUN.
        applyStimulus("wmid_start", 1'b0, 16'hE405, 1'b0, 1'b0, 1'b0, STALL);
        applyStimulus("wmid_wait",  1'b0, 16'hE405, 1'b0, 1'b0, 1'b0, ZERO);
        applyStimulus("wmid_reset", 1'b1, 16'hE405, 1'b0, 1'b0, 1'b0, ZERO);
        applyStimulus("wmid_run",   1'b0, 16'hE200, 1'b0, 1'b0, 1'b0, NOPV);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
